i2c_eeprom_slave: RTL and testbench

//  I2C target that emulates a 24C02-class EEPROM (256 x 8) inside the FPGA.

---
 rtl/i2c_slv_pkg.sv | 27 ++
 rtl/i2c_slv_cond_det.sv | 45 ++++
 rtl/i2c_eeprom_slave.sv | 201 ++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slv_pkg.sv
// Shared types and constants for the I2C target that emulates a 24C02-class EEPROM.
package i2c_slv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_WADDR,
    ST_WADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_MACK
  } state_e;

  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;
  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'b1010000;
  localparam int         RW_BIT           = 0;
  localparam logic [3:0] BYTE_BITS        = 4'd8;

  // Word pointer advance with wrap at the top of the array.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input int depth);
    return (int'(ptr) >= depth - 1) ? 8'h00 : ptr + 8'h01;
  endfunction

endpackage

// File: rtl/i2c_slv_cond_det.sv
// Synchronizes scl/sda, produces 1-cycle scl edge pulses and START/STOP detection.
module i2c_slv_cond_det #(
  parameter int SYNC_STG = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [SYNC_STG-1:0] scl_sync_q;
  logic [SYNC_STG-1:0] sda_sync_q;
  logic                scl_prev_q;
  logic                sda_prev_q;
  logic                scl_s;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STG-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STG-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_o;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STG-1];
  assign sda_o      = sda_sync_q[SYNC_STG-1];
  assign scl_rise_o = scl_s & ~scl_prev_q;
  assign scl_fall_o = ~scl_s & scl_prev_q;
  // Both scl samples high so a data change racing an scl edge is never taken as START/STOP.
  assign start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_o;
  assign stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_o;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 256x8 EEPROM: byte/sequential write, current/random/sequential read.
// Define I2C_SLV_WP_EN to add the wp write-protect input.
module i2c_eeprom_slave
  import i2c_slv_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
  parameter int         MEM_DEPTH = 256,
  parameter int         SYNC_STG  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
`ifdef I2C_SLV_WP_EN
  input  logic       wp,
`endif
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] wr_data,
  output logic       busy
);

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] dbg_data_q;
  logic       sda_oe_q, sda_oe_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       busy_q, busy_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic       mem_we, load_rd, byte_done, wp_s;
  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] mem_rd;
  logic       sda_s, scl_rise, scl_fall, start, stop;

`ifdef I2C_SLV_WP_EN
  assign wp_s = wp;
`else
  assign wp_s = 1'b0;
`endif

  i2c_slv_cond_det #(.SYNC_STG(SYNC_STG)) u_cond_det (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start),
    .stop_o    (stop)
  );

  assign mem_rd    = mem_q[ptr_q];
  assign byte_done = scl_fall && (bit_cnt_q == BYTE_BITS);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    busy_d      = busy_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    mem_we      = 1'b0;
    load_rd     = 1'b0;

    if (start || stop) begin
      state_d   = start ? ST_DEV : ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_DEV, ST_WADDR, ST_WR_BYTE: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            bit_cnt_d = '0;
            if (state_q == ST_DEV) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_d  = ST_DEV_ACK;
                sda_oe_d = 1'b1;
                rw_d     = shift_q[RW_BIT];
                busy_d   = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (state_q == ST_WADDR) begin
              state_d  = ST_WADDR_ACK;
              ptr_d    = shift_q;
              sda_oe_d = 1'b1;
            end else begin
              // Protected bytes fall through to WR_ACK with sda released, i.e. a NACK.
              state_d = ST_WR_ACK;
              if (!wp_s) begin
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_data_d   = shift_q;
                ptr_d       = ptr_inc(ptr_q, MEM_DEPTH);
                sda_oe_d    = 1'b1;
              end
            end
          end
        end
        ST_DEV_ACK, ST_WADDR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            if (state_q == ST_DEV_ACK && rw_q) begin
              load_rd = 1'b1;
            end else if (state_q == ST_DEV_ACK) begin
              state_d = ST_WADDR;
            end else begin
              state_d = ST_WR_BYTE;
            end
          end
        end
        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d   = ST_MACK;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            mack_d    = 1'b0;
            ptr_d     = ptr_inc(ptr_q, MEM_DEPTH);
          end else if (scl_fall) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        ST_MACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) state_d = ST_IDLE;
            else if (sda_s == ACK) mack_d = 1'b1;
          end else if (scl_fall && mack_q) begin
            load_rd = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Next read byte is loaded on the scl fall so its MSB is on the bus before the next rise.
    if (load_rd) begin
      state_d   = ST_RD_BYTE;
      bit_cnt_d = '0;
      shift_d   = mem_rd;
      sda_oe_d  = ~mem_rd[7];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_data_q   <= '0;
      dbg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_data_q   <= wr_data_d;
      dbg_data_q  <= mem_q[dbg_addr];
    end
  end

  // NOTE: the storage array has no reset, so it maps onto plain RAM and keeps contents over reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[ptr_q] <= shift_q;
  end

  assign sda       = sda_oe_q ? 1'b0 : 1'bz;
  assign dbg_data  = dbg_data_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Scoreboard bench: bus master at clk/100 with pull-up, EEPROM reference model, decoupled monitors.
module tb_i2c_eeprom_slave;

  localparam int T4 = 250;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       scl      = 1'b1;
  logic       m_oe     = 1'b0;
  logic [7:0] dbg_addr = 8'h00;
  logic [7:0] dbg_data, wr_data;
  logic       wr_strobe, busy;
  wire        sda;
`ifdef I2C_SLV_WP_EN
  logic       wp = 1'b0;
`endif

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] mem_m [256];
  logic [7:0] ptr_m = 8'h00;
  string      exp_name_q[$];
  int         exp_val_q[$];
  int         obs_q[$];
  logic [7:0] exp_wr_q[$];
  logic [7:0] wq[$];
  bit         quiet   = 1'b0;
  int         low_cnt = 0;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_eeprom_slave dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
`ifdef I2C_SLV_WP_EN
    .wp       (wp),
`endif
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_strobe(wr_strobe),
    .wr_data  (wr_data),
    .busy     (busy)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_v(input string name, input int v);
    exp_name_q.push_back(name);
    exp_val_q.push_back(v);
  endtask

  task automatic observe(input int v);
    obs_q.push_back(v);
  endtask

  // Scoreboard monitor: pairs each observation with the oldest expectation.
  initial forever begin
    @(negedge clk);
    while (obs_q.size() > 0) begin
      int o;
      o = obs_q.pop_front();
      if (exp_val_q.size() == 0) check("orphan_observation", 1, 0);
      else check(exp_name_q.pop_front(), o, exp_val_q.pop_front());
    end
  end

  // Commit monitor: every wr_strobe must match a byte the model committed.
  initial forever begin
    @(negedge clk);
    if (rst && wr_strobe) begin
      if (exp_wr_q.size() == 0) check("wr_strobe_unexpected", 1, 0);
      else check("wr_data", int'(wr_data), int'(exp_wr_q.pop_front()));
    end
  end

  initial forever begin
    @(negedge clk);
    if (quiet && !m_oe && sda !== 1'b1) low_cnt++;
  end

  initial begin
    #950000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit");
  end

  task automatic start_cond();
    m_oe = 1'b0; #T4; scl = 1'b1; #T4; m_oe = 1'b1; #T4; scl = 1'b0; #T4;
  endtask

  task automatic stop_cond();
    m_oe = 1'b1; #T4; scl = 1'b1; #T4; m_oe = 1'b0; #T4;
  endtask

  task automatic send_bit(input logic b);
    m_oe = ~b; #T4; scl = 1'b1; #(2 * T4); scl = 1'b0; #T4;
  endtask

  task automatic recv_bit(output logic b);
    m_oe = 1'b0; #T4; scl = 1'b1; #T4; b = sda; #T4; scl = 1'b0; #T4;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    send_bit(nack);
  endtask

  // Write transaction: control byte, word address, then every byte queued in wq.
  task automatic do_write(input logic [7:0] addr, input bit wp_on);
    logic a;
    start_cond();
    expect_v("dev_ack", 0);   send_byte(8'hA0, a); observe(int'(a));
    expect_v("busy_set", 1);  observe(int'(busy));
    expect_v("waddr_ack", 0); send_byte(addr, a);  observe(int'(a));
    ptr_m = addr;
    foreach (wq[i]) begin
      if (!wp_on) exp_wr_q.push_back(wq[i]);
      expect_v("data_ack", wp_on ? 1 : 0);
      send_byte(wq[i], a);
      observe(int'(a));
      if (!wp_on) begin
        mem_m[ptr_m] = wq[i];
        ptr_m = 8'((int'(ptr_m) + 1) % 256);
      end
    end
    stop_cond();
    expect_v("busy_clear", 0); observe(int'(busy));
  endtask

  // Read n bytes, from addr (dummy write + repeated START) or from the current pointer.
  task automatic do_read(input bit random_addr, input logic [7:0] addr, input int n);
    logic       a;
    logic [7:0] d;
    start_cond();
    if (random_addr) begin
      expect_v("rd_dev_ack", 0);   send_byte(8'hA0, a); observe(int'(a));
      expect_v("rd_waddr_ack", 0); send_byte(addr, a);  observe(int'(a));
      ptr_m = addr;
      start_cond();
    end
    expect_v("rd_ctrl_ack", 0); send_byte(8'hA1, a); observe(int'(a));
    for (int i = 0; i < n; i++) begin
      expect_v("rd_data", int'(mem_m[ptr_m]));
      recv_byte(i == n - 1, d);
      observe(int'(d));
      ptr_m = 8'((int'(ptr_m) + 1) % 256);
    end
    stop_cond();
  endtask

  task automatic check_dbg(input logic [7:0] a);
    @(negedge clk);
    dbg_addr = a;
    @(negedge clk);
    @(negedge clk);
    expect_v("dbg_data", int'(mem_m[a]));
    observe(int'(dbg_data));
  endtask

  initial begin
    logic a;
    repeat (5) @(negedge clk);
    expect_v("rst_sda", 1);       observe(int'(sda));
    expect_v("rst_wr_strobe", 0); observe(int'(wr_strobe));
    expect_v("rst_wr_data", 0);   observe(int'(wr_data));
    expect_v("rst_busy", 0);      observe(int'(busy));
    expect_v("rst_dbg_data", 0);  observe(int'(dbg_data));
    rst = 1'b1;
    repeat (5) @(negedge clk);

    wq.delete();
    for (int i = 0; i < 12; i++) wq.push_back(8'($urandom));
    do_write(8'h00, 1'b0);

    wq.delete(); wq.push_back(8'h05);
    do_write(8'h0A, 1'b0);
    check_dbg(8'h0A);
    do_read(1'b1, 8'h0A, 1);
    do_read(1'b0, 8'h00, 1);

    wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
    do_write(8'hFF, 1'b0);
    do_read(1'b1, 8'hFF, 2);
    check_dbg(8'hFF);

    // Foreign device address: target must stay off the bus until the next START.
    start_cond();
    quiet = 1'b1;
    expect_v("wrong_dev_nack", 1); send_byte(8'hA4, a); observe(int'(a));
    expect_v("wrong_busy", 0);     observe(int'(busy));
    expect_v("wrong_nack1", 1);    send_byte(8'h0A, a); observe(int'(a));
    expect_v("wrong_nack2", 1);    send_byte(8'h55, a); observe(int'(a));
    stop_cond();
    quiet = 1'b0;
    expect_v("wrong_sda_low_samples", 0); observe(low_cnt);
    check_dbg(8'h0A);

    start_cond();
    expect_v("abort_dev_ack", 0);   send_byte(8'hA0, a); observe(int'(a));
    expect_v("abort_waddr_ack", 0); send_byte(8'h0A, a); observe(int'(a));
    ptr_m = 8'h0A;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    stop_cond();
    check_dbg(8'h0A);

`ifdef I2C_SLV_WP_EN
    wp = 1'b1;
    wq.delete(); wq.push_back(8'h33);
    do_write(8'h0A, 1'b1);
    wp = 1'b0;
    check_dbg(8'h0A);
`endif

    for (int it = 0; it < 2; it++) begin
      logic [7:0] wa, ra;
      int         wn, rn;
      wa = 8'($urandom_range(0, 10));
      wn = $urandom_range(1, 2);
      wq.delete();
      for (int i = 0; i < wn; i++) wq.push_back(8'($urandom));
      do_write(wa, 1'b0);
      ra = 8'($urandom_range(0, 9));
      rn = $urandom_range(1, 2);
      do_read(1'b1, ra, rn);
      do_read(1'b0, 8'h00, 1);
    end

    // Reset while the target is driving ACK must release sda immediately.
    @(negedge clk);
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(a == a ? 8'hA0 >> i : 1'b0);
    m_oe = 1'b0;
    #T4;
    expect_v("ack_driven", 0); observe(int'(sda));
    @(negedge clk);
    rst = 1'b0;
    #1;
    expect_v("rst_mid_sda", 1);  observe(int'(sda));
    expect_v("rst_mid_busy", 0); observe(int'(busy));
    @(negedge clk);
    rst = 1'b1;
    scl = 1'b1;
    #(4 * T4);
    @(negedge clk);
    ptr_m = 8'h00;
    do_read(1'b0, 8'h00, 1);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_val_q.size(), 0);
    check("commits_drained", exp_wr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
